// File: rtl/sobel_window.sv
// 3x3 window generator for a Sobel operator: two line buffers plus a shift window,
// emitting only interior windows of an IMG_W x IMG_H frame.
module sobel_window #(
   parameter int IMG_W = 352,
   parameter int IMG_H = 288
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] pix_in,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic [7:0] s11,
   output logic [7:0] s12,
   output logic [7:0] s13,
   output logic [7:0] s21,
   output logic [7:0] s22,
   output logic [7:0] s23,
   output logic [7:0] s31,
   output logic [7:0] s32,
   output logic [7:0] s33,
   output logic       win_valid,
   output logic       frame_done,
   output logic       busy
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_pix_ready;
   logic          r_win_valid;
   logic          r_frame_done;
   logic          r_busy;
   logic [7:0]    r_s [9];
   logic [7:0]    r_lb1 [IMG_W];
   logic [7:0]    r_lb2 [IMG_W];
   logic [7:0]    r_wl [3];
   logic [7:0]    r_wm [3];

   logic          w_acc;
   logic          w_emit;
   logic [7:0]    w_top;
   logic [7:0]    w_mid;

   assign w_acc  = (r_state == RUN) && pix_valid;
   assign w_top  = r_lb2[r_col];
   assign w_mid  = r_lb1[r_col];
   assign w_emit = w_acc && (r_row >= RW'(2)) && (r_col >= CW'(2));

   // Line buffers carry no reset; every entry read for an emitted window is rewritten first.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_lb2[r_col] <= r_lb1[r_col];
         r_lb1[r_col] <= pix_in;
      end
   end

   // Internal columns shift on every accept; outputs load only on an emitting accept so they hold otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_pix_ready  <= 1'b0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_s          <= '{default: '0};
         r_wl         <= '{default: '0};
         r_wm         <= '{default: '0};
      end else begin
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= RUN;
                  r_col       <= '0;
                  r_row       <= '0;
                  r_pix_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            RUN: begin
               if (w_acc) begin
                  r_wl    <= r_wm;
                  r_wm[0] <= w_top;
                  r_wm[1] <= w_mid;
                  r_wm[2] <= pix_in;
                  if (w_emit) begin
                     r_s[0]      <= r_wl[0];
                     r_s[1]      <= r_wm[0];
                     r_s[2]      <= w_top;
                     r_s[3]      <= r_wl[1];
                     r_s[4]      <= r_wm[1];
                     r_s[5]      <= w_mid;
                     r_s[6]      <= r_wl[2];
                     r_s[7]      <= r_wm[2];
                     r_s[8]      <= pix_in;
                     r_win_valid <= 1'b1;
                  end
                  if (r_col == COL_LAST) begin
                     r_col <= '0;
                     if (r_row == ROW_LAST) begin
                        r_state      <= DONE;
                        r_pix_ready  <= 1'b0;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_row <= r_row + RW'(1);
                     end
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pix_ready  = r_pix_ready;
   assign win_valid  = r_win_valid;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;
   assign s11 = r_s[0];
   assign s12 = r_s[1];
   assign s13 = r_s[2];
   assign s21 = r_s[3];
   assign s22 = r_s[4];
   assign s23 = r_s[5];
   assign s31 = r_s[6];
   assign s32 = r_s[7];
   assign s33 = r_s[8];

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 SHALL have parameter IMG_W, default 352, meaning pixels per image row (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 288, meaning rows per image (legal range 3..1024).
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a frame.
REQ-006 SHALL have port pix_in, input, 8 bits, meaning the unsigned pixel, row-major, top-left first.
REQ-007 SHALL have port pix_valid, input, 1 bit, meaning pix_in carries a pixel this cycle.
REQ-008 SHALL have port pix_ready, output, 1 bit, meaning the block accepts a pixel this cycle.
REQ-009 SHALL have ports s11, s12, s13, s21, s22, s23, s31, s32, s33, output, 8 bits each, meaning the 3x3 window; the first digit is the row (1 = top) and the second digit is the column (1 = left). These ports connect directly to the same-named inputs of the sobel operator.
REQ-010 SHALL have port win_valid, output, 1 bit, meaning s11..s33 hold a new complete window.
REQ-011 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse at the end of the frame.
REQ-012 SHALL have port busy, output, 1 bit, meaning a frame is in progress.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
- IDLE -> RUN on start = 1; this clears row and column counters.
- RUN -> DONE on the edge that accepts pixel (IMG_H-1, IMG_W-1).
- DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL drive pix_ready = 1 only in RUN; a pixel is accepted when pix_valid = 1 and pix_ready = 1.
REQ-015 SHALL ignore pix_valid in IDLE and DONE, and ignore start in RUN and DONE.
REQ-016 SHALL advance the column counter on each accept. The column counter wraps from IMG_W-1 to 0 and increments the row counter on wrap.
REQ-017 SHALL hold all counters and the window unchanged on cycles without an accept; gaps in pix_valid of any length are legal.
REQ-018 SHALL keep two IMG_W x 8 line buffers holding the previous two rows, plus a 3x3 shift-register window. Accepted pixels enter column 3 (the right column).
REQ-019 SHALL emit the window centred on (r,c) for every interior pixel only: 1 <= r <= IMG_H-2 and 1 <= c <= IMG_W-2. No border windows and no padding.
REQ-020 SHALL assert win_valid for exactly one cycle, the cycle after the edge that accepts pixel (r+1,c+1), with s11..s33 registered and valid in that same cycle.
REQ-021 SHALL produce exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per frame.
REQ-022 SHALL hold s11..s33 at their last value while win_valid = 0.
REQ-023 SHALL assert frame_done only in DONE; this cycle coincides with the final win_valid pulse.
REQ-024 SHALL assert busy in RUN and DONE and deassert it in IDLE.
REQ-025 SHALL ensure that windows never mix rows across a row wrap, including back-to-back accepts across the row boundary.
REQ-026 SHALL accept a start asserted in the first IDLE cycle after DONE and begin a new frame with no stale data emitted.

Reset
REQ-027 SHALL, on reset_n = 0 and independent of clk, set the state to IDLE, zero all counters, and drive pix_ready, win_valid, frame_done and busy to 0 and s11..s33 to 0.
REQ-028 SHALL abort a frame interrupted by reset; after release, the block waits in IDLE for start. Line-buffer contents need not be reset.

Verification (IMG_W=4, IMG_H=3 unless noted)
REQ-029 SHALL verify the basic frame: start, then pixels 0..11 on consecutive cycles.
- win_valid pulses after pixel 10 with rows 0 1 2 / 4 5 6 / 8 9 10.
- win_valid pulses after pixel 11 with rows 1 2 3 / 5 6 7 / 9 10 11.
- frame_done is high in the same cycle as the second pulse.
- Exactly 2 pulses in total.
REQ-030 SHALL verify gaps: the same frame with pix_valid low for 3 cycles between every pixel produces identical windows, win_valid stays 0 during gaps, and the outputs hold.
REQ-031 SHALL verify idle behaviour: pixels presented before start, and start asserted during RUN, cause no effect; pix_ready = 0 in IDLE.
REQ-032 SHALL verify reset mid-frame: reset_n pulsed low after pixel 6 forces all outputs to 0 immediately; a fresh start plus pixels 0..11 then gives the windows of REQ-029.
REQ-033 SHALL verify back-to-back frames: start in the cycle after DONE, with a second frame of pixels 100..111, gives windows 100 101 102 / 104 105 106 / 108 109 110 and 101 102 103 / 105 106 107 / 109 110 111.
REQ-034 SHALL verify the default-size frame: IMG_W=352, IMG_H=288 with a random frame gives 350*286 = 100100 windows, each equal to a reference model and driving the sobel operator without mismatch.
